oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Bus initiator that implements the Game Boy OAM DMA engine. A CPU-side write to 0xFF46 triggers a copy of 160 bytes from {src_hi,8'h00}..{src_hi,8'h9F} into OAM at 0xFE00..0xFE9F.
- It masters the same byte-wide data bus that whizgraphics answers on as a peripheral, so it is the initiator end of that protocol.
- It sits between the CPU register path and the shared bus arbiter.
- It raises dma_active so the CPU core stalls non-HRAM accesses.

Parameters:
- CLKS_PER_BYTE, 4, clocks per transferred byte (one M-cycle); legal values 4..16.
- START_DELAY, 4, clocks between the trigger write and the first bus read.
- ECHO_FOLD, 1, when 1 a source page of 0xE0..0xFF is folded to 0xC0..0xDF (echo RAM).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- reg_addr  input  16  CPU register-path address
- reg_wdata  input  8  CPU write data
- reg_we  input  1  CPU write strobe, one cycle
- reg_re  input  1  CPU read strobe, one cycle
- reg_rdata  output  8  register read data, valid the cycle after reg_re
- reg_hit  output  1  high the cycle after reg_re/reg_we when reg_addr==0xFF46
- bus_addr  output  16  initiator address
- bus_wdata  output  8  initiator write data
- bus_rd  output  1  read request, one clock
- bus_wr  output  1  write request, one clock
- bus_rdata  input  8  responder data, valid exactly 1 clock after bus_rd
- dma_active  output  1  high from the trigger until the last OAM write completes

Behaviour:
- Reset values:
  - All outputs are 0.
  - src_reg = 8'h00, byte index = 0, state = IDLE.
- Register access:
  - A write to 0xFF46 latches src_reg and triggers a transfer.
  - A read of 0xFF46 returns src_reg at any time, including mid-transfer.
  - Any other address leaves reg_hit = 0 and reg_rdata = 0.
- States:
  - IDLE -> DELAY on a trigger; dma_active rises on the clock after the write.
  - DELAY counts START_DELAY clocks, then goes to XFER with index = 0.
  - XFER: each byte slot is CLKS_PER_BYTE clocks with phase counter p = 0..CLKS_PER_BYTE-1:
    - p=0: bus_rd=1, bus_addr = {fold(src_reg),index}.
    - p=1: capture bus_rdata into a data register.
    - p=2: bus_wr=1, bus_addr = 16'hFE00+index, bus_wdata = captured byte.
    - p>=3: bus idle, bus_addr held.
  - After the slot where index==159 completes -> DONE.
  - DONE lasts 1 clock with dma_active still high, then IDLE with dma_active=0.
- Total trigger-to-idle latency = 1 + START_DELAY + 160*CLKS_PER_BYTE + 1 clocks; 646 clocks at the defaults.
- Index is 8 bits and never exceeds 159; OAM address arithmetic is 16-bit with no wrap.
- fold(x) = (ECHO_FOLD && x>=8'hE0) ? x-8'h20 : x.
- bus_rd and bus_wr are never high in the same clock.
- Retrigger while active:
  - The new write updates src_reg immediately.
  - Any in-flight write at p=2 of the current cycle still completes.
  - The FSM then restarts at DELAY with index 0.
  - dma_active stays continuously high.
- A write and a read of 0xFF46 in the same cycle: the write wins, and the read returns the new value the next cycle.
- A reset mid-transfer aborts on the next edge: bus strobes drop to 0 and no partial write is issued afterwards.

Decomposition:
- Additions to the shared video_types package:
  - constants DMA_REG_ADDR=16'hFF46, OAM_BASE=16'hFE00, OAM_BYTES=160.
  - typedef enum dma_state_t {IDLE, DELAY, XFER, DONE}.
- One natural sub-module: dma_slot_timer.
  - A phase counter with parameter CLKS_PER_BYTE.
  - Outputs rd_phase, cap_phase, wr_phase, slot_end.
  - Sync clear on restart.
- The top level holds the register, the index, the FSM and the bus muxing.

Test Plan:
- Write 0xC1 to 0xFF46 with a memory model holding byte(i) = i^0x5A at 0xC100+i:
  - 160 writes to 0xFE00..0xFE9F with matching data.
  - dma_active is high for exactly 645 clocks.
  - The first bus_rd occurs 5 clocks after reg_we.
- Read 0xFF46 at clock 300 of a 0x80 transfer -> reg_rdata = 0x80 and reg_hit = 1; the transfer is unaffected.
- Write 0xE3 with ECHO_FOLD=1 -> reads start at 0xC300 and end at 0xC39F; repeat with ECHO_FOLD=0 -> reads at 0xE300.
- Retrigger with 0xD0 after byte 50 of a 0xC0 transfer:
  - byte 50 write completes.
  - the next read is 0xD000 after START_DELAY.
  - 160 further writes follow.
  - dma_active never drops.
- Assert reset at byte 80 -> bus_rd, bus_wr and dma_active are all 0 next clock, with no further writes; a following trigger runs a full 160-byte transfer.
- Checker over all runs: bus_rd and bus_wr are never both high, and no write targets an address outside 0xFE00..0xFE9F.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the OAM DMA engine.
//   DMA_REG_ADDR : CPU register that triggers a transfer
//   OAM_BASE     : first OAM byte written by the engine
//   OAM_BYTES    : bytes copied per transfer
//   dma_state_t  : engine FSM states
//   fold_page    : maps echo-RAM source pages onto work RAM
package oam_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int unsigned OAM_BYTES    = 160;
  localparam logic [7:0]  LAST_INDEX   = 8'(OAM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    XFER,
    DONE
  } dma_state_t;

  // Pages 0xE0..0xFF mirror 0xC0..0xDF when folding is enabled.
  function automatic logic [7:0] fold_page(input logic [7:0] page, input logic fold_en);
    return (fold_en && (page >= 8'hE0)) ? (page - 8'h20) : page;
  endfunction

endpackage

// File: rtl/oam_dma_slot_timer.sv
// Phase counter for one DMA byte slot (CLKS_PER_BYTE clocks per byte).
//   clk, reset   : system clock, synchronous active-high reset
//   i_clear      : synchronous restart of the slot at phase 0
//   i_en         : advance the phase this clock
//   o_rd_phase   : phase 0, bus read request
//   o_cap_phase  : phase 1, read data is on the bus
//   o_wr_phase   : phase 2, OAM write request
//   o_slot_end   : last phase of the slot
module dma_slot_timer #(
  parameter int unsigned CLKS_PER_BYTE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_rd_phase,
  output logic o_cap_phase,
  output logic o_wr_phase,
  output logic o_slot_end
);

  localparam logic [4:0] LAST_PHASE = 5'(CLKS_PER_BYTE - 1);

  logic [4:0] r_phase;
  logic       w_slot_end;

  assign w_slot_end  = (r_phase == LAST_PHASE);
  assign o_slot_end  = w_slot_end;
  assign o_rd_phase  = (r_phase == 5'd0);
  assign o_cap_phase = (r_phase == 5'd1);
  assign o_wr_phase  = (r_phase == 5'd2);

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_phase <= '0;
    end else if (i_en) begin
      r_phase <= w_slot_end ? '0 : (r_phase + 5'd1);
    end
  end

endmodule

// File: rtl/oam_dma.sv
// Game Boy OAM DMA initiator. A CPU write to 0xFF46 copies 160 bytes from
// page {src,00..9F} into OAM 0xFE00..0xFE9F over the shared byte bus.
//   clk, reset            : system clock, synchronous active-high reset
//   reg_addr/wdata/we/re  : CPU register path
//   reg_rdata, reg_hit    : registered read data / address hit
//   bus_addr/wdata/rd/wr  : initiator side of the byte bus
//   bus_rdata             : responder data, one clock after bus_rd
//   dma_active            : transfer in progress (CPU stalls non-HRAM)
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int unsigned CLKS_PER_BYTE = 4,
  parameter int unsigned START_DELAY   = 4,
  parameter int unsigned ECHO_FOLD     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        reg_we,
  input  logic        reg_re,
  output logic [7:0]  reg_rdata,
  output logic        reg_hit,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic [7:0]  bus_rdata,
  output logic        dma_active
);

  localparam logic [15:0] LAST_DELAY = 16'(START_DELAY - 1);

  dma_state_t  r_state, w_next;
  logic [7:0]  r_src, r_index, r_data, r_rdata;
  logic [15:0] r_dly;
  logic        r_hit;
  logic        w_addr_hit, w_trig, w_rd_hit;
  logic        w_rd_phase, w_cap_phase, w_wr_phase, w_slot_end;
  logic        w_xfer;
  logic [15:0] w_rd_addr, w_wr_addr;

  assign w_addr_hit = (reg_addr == DMA_REG_ADDR);
  assign w_trig     = reg_we && w_addr_hit;
  assign w_rd_hit   = reg_re && w_addr_hit;
  assign w_xfer     = (r_state == XFER);

  // Any trigger restarts the slot; an in-flight phase-2 write has already
  // been presented on the bus this clock, so it completes untouched.
  dma_slot_timer #(.CLKS_PER_BYTE(CLKS_PER_BYTE)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_trig || !w_xfer),
    .i_en       (w_xfer),
    .o_rd_phase (w_rd_phase),
    .o_cap_phase(w_cap_phase),
    .o_wr_phase (w_wr_phase),
    .o_slot_end (w_slot_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_index <= '0;
      r_data  <= '0;
      r_dly   <= '0;
      r_rdata <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hit   <= (reg_we || reg_re) && w_addr_hit;
      // Same-cycle write and read: the read observes the new value.
      r_rdata <= w_rd_hit ? (w_trig ? reg_wdata : r_src) : '0;
      if (w_trig) r_src <= reg_wdata;
      r_dly <= ((r_state == DELAY) && !w_trig) ? (r_dly + 16'd1) : '0;
      if (w_trig || !w_xfer) begin
        r_index <= '0;
      end else if (w_slot_end && (r_index != LAST_INDEX)) begin
        r_index <= r_index + 8'd1;
      end
      if (w_xfer && w_cap_phase) r_data <= bus_rdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_trig) w_next = DELAY;
      DELAY:   if (!w_trig && (r_dly == LAST_DELAY)) w_next = XFER;
      XFER: begin
        if (w_trig) w_next = DELAY;
        else if (w_slot_end && (r_index == LAST_INDEX)) w_next = DONE;
      end
      DONE:    w_next = w_trig ? DELAY : IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_rd_addr = {fold_page(r_src, ECHO_FOLD != 0), r_index};
  assign w_wr_addr = OAM_BASE + {8'h00, r_index};

  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    if (w_xfer) begin
      if (w_rd_phase || w_cap_phase) begin
        bus_addr = w_rd_addr;
        bus_rd   = w_rd_phase;
      end else begin
        bus_addr = w_wr_addr;
        if (w_wr_phase) begin
          bus_wr    = 1'b1;
          bus_wdata = r_data;
        end
      end
    end
  end

  assign dma_active = (r_state != IDLE);
  assign reg_rdata  = r_rdata;
  assign reg_hit    = r_hit;

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] reg_addr = '0;
  logic [7:0]  reg_wdata = '0;
  logic        reg_we = 1'b0, reg_we2 = 1'b0, reg_re = 1'b0;
  logic [7:0]  reg_rdata1, reg_rdata2, bus_wdata1, bus_wdata2;
  logic        reg_hit1, reg_hit2, bus_rd1, bus_rd2, bus_wr1, bus_wr2;
  logic        dma_active1, dma_active2;
  logic [15:0] bus_addr1, bus_addr2;
  logic [7:0]  bus_rdata1 = '0, bus_rdata2 = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int viol = 0;
  int act1 = 0;
  int falls1 = 0;
  logic prev_act1 = 1'b0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          stamp;
  } ev_t;
  ev_t wq1[$], rq1[$], wq2[$], rq2[$];

  logic [7:0] mem [0:65535];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-bus responders: data valid the clock after bus_rd.
  always @(posedge clk) begin
    if (bus_rd1) bus_rdata1 <= mem[bus_addr1];
    if (bus_rd2) bus_rdata2 <= mem[bus_addr2];
  end

  oam_dma #(.CLKS_PER_BYTE(4), .START_DELAY(4), .ECHO_FOLD(1)) u_dut (
    .clk(clk), .reset(reset), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata1), .reg_hit(reg_hit1),
    .bus_addr(bus_addr1), .bus_wdata(bus_wdata1), .bus_rd(bus_rd1), .bus_wr(bus_wr1),
    .bus_rdata(bus_rdata1), .dma_active(dma_active1)
  );

  oam_dma #(.CLKS_PER_BYTE(4), .START_DELAY(4), .ECHO_FOLD(0)) u_dut_nofold (
    .clk(clk), .reset(reset), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we2), .reg_re(reg_re), .reg_rdata(reg_rdata2), .reg_hit(reg_hit2),
    .bus_addr(bus_addr2), .bus_wdata(bus_wdata2), .bus_rd(bus_rd2), .bus_wr(bus_wr2),
    .bus_rdata(bus_rdata2), .dma_active(dma_active2)
  );

  // Bus monitor: logs transactions stamped with the clock edge that samples
  // them, and counts protocol violations.
  always @(negedge clk) begin
    if (bus_rd1) rq1.push_back('{bus_addr1, 8'h00, cyc + 1});
    if (bus_wr1) wq1.push_back('{bus_addr1, bus_wdata1, cyc + 1});
    if (bus_rd2) rq2.push_back('{bus_addr2, 8'h00, cyc + 1});
    if (bus_wr2) wq2.push_back('{bus_addr2, bus_wdata2, cyc + 1});
    if (bus_rd1 && bus_wr1) viol++;
    if (bus_rd2 && bus_wr2) viol++;
    if (bus_wr1 && (bus_addr1 < 16'hFE00 || bus_addr1 > 16'hFE9F)) viol++;
    if (bus_wr2 && (bus_addr2 < 16'hFE00 || bus_addr2 > 16'hFE9F)) viol++;
    if (dma_active1) act1++;
    if (prev_act1 && !dma_active1) falls1++;
    prev_act1 = dma_active1;
  end

  // Reference: source address of byte i for a given page written to FF46.
  function automatic logic [15:0] src_addr(input logic [7:0] page, input int i, input bit fold);
    int p;
    p = page;
    if (fold && p >= 224) p = p - 32;
    return 16'(p * 256 + i);
  endfunction

  task automatic clear_logs();
    wq1.delete(); rq1.delete(); wq2.delete(); rq2.delete();
    act1 = 0; falls1 = 0;
  endtask

  task automatic trig(input bit sel, input logic [7:0] page, output int e);
    @(negedge clk);
    reg_addr = 16'hFF46; reg_wdata = page;
    if (sel) reg_we2 = 1'b1; else reg_we = 1'b1;
    @(negedge clk);
    e = cyc;
    reg_we = 1'b0; reg_we2 = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((dma_active1 || dma_active2) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (dma_active1 || dma_active2) begin
      errors++;
      $display("FAIL %s_timeout dma_active still %b/%b after %0d clocks", nm, dma_active1, dma_active2, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_rd1, bus_wr1, dma_active1, reg_hit1, bus_rd2, bus_wr2, dma_active2, reg_hit2} !== 8'h00) begin
      errors++;
      $display("FAIL reset_strobes got %b want 00000000",
               {bus_rd1, bus_wr1, dma_active1, reg_hit1, bus_rd2, bus_wr2, dma_active2, reg_hit2});
    end
    checks++;
    if ({bus_addr1, bus_wdata1, reg_rdata1} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h want 0", bus_addr1, bus_wdata1, reg_rdata1);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int e;
    for (int i = 0; i < 160; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
    clear_logs();
    trig(1'b0, 8'hC1, e);
    wait_idle("basic");
    checks++;
    if (wq1.size() != 160 || rq1.size() != 160) begin
      errors++;
      $display("FAIL basic_count got %0d writes %0d reads want 160", wq1.size(), rq1.size());
    end
    for (int i = 0; i < 160 && i < wq1.size() && i < rq1.size(); i++) begin
      checks++;
      if (wq1[i].addr !== 16'(16'hFE00 + i) || wq1[i].data !== (8'(i) ^ 8'h5A) ||
          rq1[i].addr !== 16'(16'hC100 + i)) begin
        errors++;
        $display("FAIL basic_byte%0d got wr %h=%h rd %h want wr %h=%h rd %h", i,
                 wq1[i].addr, wq1[i].data, rq1[i].addr, 16'(16'hFE00 + i), 8'(i) ^ 8'h5A, 16'(16'hC100 + i));
      end
    end
    checks++;
    if (act1 != 645) begin
      errors++;
      $display("FAIL basic_active_len got %0d want 645", act1);
    end
    checks++;
    if (rq1.size() == 0 || rq1[0].stamp - e != 5) begin
      errors++;
      $display("FAIL basic_first_read got %0d want 5", rq1.size() == 0 ? -1 : rq1[0].stamp - e);
    end
  endtask

  task automatic test_reg_read();
    int e;
    clear_logs();
    @(negedge clk);
    reg_addr = 16'hFF46; reg_wdata = 8'h80; reg_we = 1'b1; reg_re = 1'b1;
    @(negedge clk);
    e = cyc;
    reg_we = 1'b0; reg_re = 1'b0;
    checks++;
    if (reg_rdata1 !== 8'h80 || reg_hit1 !== 1'b1) begin
      errors++;
      $display("FAIL wr_rd_same got %h hit %b want 80 hit 1", reg_rdata1, reg_hit1);
    end
    while (cyc < e + 300) @(negedge clk);
    reg_re = 1'b1;
    @(negedge clk);
    checks++;
    if (reg_rdata1 !== 8'h80 || reg_hit1 !== 1'b1) begin
      errors++;
      $display("FAIL mid_read got %h hit %b want 80 hit 1", reg_rdata1, reg_hit1);
    end
    reg_addr = 16'hFF47;
    @(negedge clk);
    reg_re = 1'b0;
    checks++;
    if (reg_rdata1 !== 8'h00 || reg_hit1 !== 1'b0) begin
      errors++;
      $display("FAIL other_addr got %h hit %b want 00 hit 0", reg_rdata1, reg_hit1);
    end
    wait_idle("reg_read");
    checks++;
    if (wq1.size() != 160 || act1 != 645) begin
      errors++;
      $display("FAIL reg_read_xfer got %0d writes %0d active want 160 645", wq1.size(), act1);
    end
    for (int i = 0; i < wq1.size() && i < 160; i++) begin
      checks++;
      if (wq1[i].addr !== 16'(16'hFE00 + i) || wq1[i].data !== mem[src_addr(8'h80, i, 1'b1)]) begin
        errors++;
        $display("FAIL reg_read_byte%0d got %h=%h want %h=%h", i, wq1[i].addr, wq1[i].data,
                 16'(16'hFE00 + i), mem[src_addr(8'h80, i, 1'b1)]);
      end
    end
  endtask

  task automatic test_echo();
    int e;
    clear_logs();
    trig(1'b0, 8'hE3, e);
    wait_idle("echo_fold");
    checks++;
    if (rq1.size() != 160 || rq1[0].addr !== 16'hC300 || rq1[159].addr !== 16'hC39F) begin
      errors++;
      $display("FAIL echo_fold_reads got n=%0d first %h last %h want 160 C300 C39F", rq1.size(),
               rq1.size() > 0 ? rq1[0].addr : 16'h0, rq1.size() > 159 ? rq1[159].addr : 16'h0);
    end
    for (int i = 0; i < wq1.size() && i < 160; i++) begin
      checks++;
      if (wq1[i].data !== mem[src_addr(8'hE3, i, 1'b1)]) begin
        errors++;
        $display("FAIL echo_fold_byte%0d got %h want %h", i, wq1[i].data, mem[src_addr(8'hE3, i, 1'b1)]);
      end
    end
    clear_logs();
    trig(1'b1, 8'hE3, e);
    wait_idle("echo_nofold");
    checks++;
    if (rq2.size() != 160 || rq2[0].addr !== 16'hE300 || rq2[159].addr !== 16'hE39F || wq2.size() != 160) begin
      errors++;
      $display("FAIL echo_nofold_reads got n=%0d first %h want 160 E300", rq2.size(),
               rq2.size() > 0 ? rq2[0].addr : 16'h0);
    end
    for (int i = 0; i < wq2.size() && i < 160; i++) begin
      checks++;
      if (wq2[i].addr !== 16'(16'hFE00 + i) || wq2[i].data !== mem[src_addr(8'hE3, i, 1'b0)]) begin
        errors++;
        $display("FAIL echo_nofold_byte%0d got %h=%h want %h", i, wq2[i].addr, wq2[i].data,
                 mem[src_addr(8'hE3, i, 1'b0)]);
      end
    end
  endtask

  task automatic test_retrigger();
    int e1, e2, n;
    clear_logs();
    trig(1'b0, 8'hC0, e1);
    n = 0;
    while (!(bus_wr1 && bus_addr1 == 16'hFE32) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL retrig_wait got no write to FE32 want one");
    end
    reg_addr = 16'hFF46; reg_wdata = 8'hD0; reg_we = 1'b1;
    @(negedge clk);
    e2 = cyc;
    reg_we = 1'b0;
    wait_idle("retrig");
    checks++;
    if (wq1.size() != 211) begin
      errors++;
      $display("FAIL retrig_count got %0d writes want 211", wq1.size());
    end
    for (int i = 0; i < wq1.size() && i < 211; i++) begin
      checks++;
      if (i < 51) begin
        if (wq1[i].addr !== 16'(16'hFE00 + i) || wq1[i].data !== mem[src_addr(8'hC0, i, 1'b1)]) begin
          errors++;
          $display("FAIL retrig_old%0d got %h=%h want %h", i, wq1[i].addr, wq1[i].data, mem[src_addr(8'hC0, i, 1'b1)]);
        end
      end else if (wq1[i].addr !== 16'(16'hFE00 + i - 51) || wq1[i].data !== mem[src_addr(8'hD0, i - 51, 1'b1)]) begin
        errors++;
        $display("FAIL retrig_new%0d got %h=%h want %h", i - 51, wq1[i].addr, wq1[i].data,
                 mem[src_addr(8'hD0, i - 51, 1'b1)]);
      end
    end
    checks++;
    if (rq1.size() < 52 || rq1[51].addr !== 16'hD000 || rq1[51].stamp - e2 != 5) begin
      errors++;
      $display("FAIL retrig_next_read got %h at +%0d want D000 at +5",
               rq1.size() > 51 ? rq1[51].addr : 16'h0, rq1.size() > 51 ? rq1[51].stamp - e2 : -1);
    end
    checks++;
    if (falls1 != 1 || act1 != e2 - e1 + 645) begin
      errors++;
      $display("FAIL retrig_active got falls %0d len %0d want 1 %0d", falls1, act1, e2 - e1 + 645);
    end
  endtask

  task automatic test_reset_abort();
    int e, n, rst_e;
    clear_logs();
    trig(1'b0, 8'hC5, e);
    n = 0;
    while (!(bus_wr1 && bus_addr1 == 16'hFE50) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    rst_e = cyc + 1;
    @(negedge clk);
    checks++;
    if (n >= 2000 || bus_rd1 !== 1'b0 || bus_wr1 !== 1'b0 || dma_active1 !== 1'b0) begin
      errors++;
      $display("FAIL abort_strobes got rd %b wr %b act %b (wait %0d) want 0 0 0", bus_rd1, bus_wr1, dma_active1, n);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (wq1.size() != 81 || wq1[wq1.size() - 1].stamp > rst_e) begin
      errors++;
      $display("FAIL abort_no_write got %0d writes want 81 none after edge %0d", wq1.size(), rst_e);
    end
    reg_addr = 16'hFF46; reg_re = 1'b1;
    @(negedge clk);
    reg_re = 1'b0;
    checks++;
    if (reg_rdata1 !== 8'h00 || reg_hit1 !== 1'b1) begin
      errors++;
      $display("FAIL abort_src_cleared got %h hit %b want 00 hit 1", reg_rdata1, reg_hit1);
    end
    clear_logs();
    trig(1'b0, 8'h42, e);
    wait_idle("abort_rerun");
    checks++;
    if (wq1.size() != 160 || act1 != 645) begin
      errors++;
      $display("FAIL abort_rerun got %0d writes %0d active want 160 645", wq1.size(), act1);
    end
    for (int i = 0; i < wq1.size() && i < 160; i++) begin
      checks++;
      if (wq1[i].addr !== 16'(16'hFE00 + i) || wq1[i].data !== mem[src_addr(8'h42, i, 1'b1)]) begin
        errors++;
        $display("FAIL abort_rerun_byte%0d got %h=%h want %h", i, wq1[i].addr, wq1[i].data, mem[src_addr(8'h42, i, 1'b1)]);
      end
    end
  endtask

  task automatic test_random();
    int e;
    logic [7:0] page;
    for (int k = 0; k < 3; k++) begin
      page = 8'($urandom);
      if (k == 0) page = 8'hFF;
      clear_logs();
      trig(1'b0, page, e);
      wait_idle("random");
      checks++;
      if (wq1.size() != 160 || rq1.size() != 160) begin
        errors++;
        $display("FAIL random_count page %h got %0d/%0d want 160", page, wq1.size(), rq1.size());
      end
      for (int i = 0; i < wq1.size() && i < 160 && i < rq1.size(); i++) begin
        checks++;
        if (rq1[i].addr !== src_addr(page, i, 1'b1) || wq1[i].addr !== 16'(16'hFE00 + i) ||
            wq1[i].data !== mem[src_addr(page, i, 1'b1)]) begin
          errors++;
          $display("FAIL random_byte%0d page %h got rd %h wr %h=%h want rd %h data %h", i, page,
                   rq1[i].addr, wq1[i].addr, wq1[i].data, src_addr(page, i, 1'b1), mem[src_addr(page, i, 1'b1)]);
        end
      end
    end
  endtask

  task automatic test_bus_rules();
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL bus_rules got %0d violations want 0", viol);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    test_reset();
    test_basic();
    test_reg_read();
    test_echo();
    test_retrigger();
    test_reset_abort();
    test_random();
    test_bus_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
